// File: rtl/multi_fifo_arbiter.sv
// N_CH independent pixel FIFOs drained through one arbitrated, registered valid/ready port.
// Arbitration is round-robin or fullest-first. Each channel has a sticky overflow flag.
module multi_fifo_arbiter #(
  parameter int N_CH        = 4,
  parameter int DEPTH       = 8,
  parameter int PIXEL_WIDTH = 16,
  parameter int ARB_MODE    = 0,
  localparam int CNT_W      = $clog2(DEPTH) + 1,
  localparam int CH_W       = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH*PIXEL_WIDTH-1:0] pix_in,
  input  logic [N_CH-1:0]             load,
  output logic [N_CH-1:0]             full,
  output logic [N_CH*CNT_W-1:0]       fill,
  output logic [N_CH-1:0]             overflow,
  input  logic                        rdy_z_buffer,
  output logic                        send_z_buffer,
  output logic [PIXEL_WIDTH-1:0]      pix_out,
  output logic [CH_W-1:0]             ch_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PIXEL_WIDTH-1:0] mem [N_CH][DEPTH];
  logic [PTR_W-1:0]       wr_ptr [N_CH];
  logic [PTR_W-1:0]       rd_ptr [N_CH];
  logic [CNT_W-1:0]       count [N_CH];
  logic [CH_W-1:0]        last_grant;

  logic                   out_free;
  logic                   grant_valid;
  logic [CH_W-1:0]        grant;
  logic [CH_W-1:0]        cand;
  logic [CNT_W-1:0]       best_cnt;
  logic [N_CH-1:0]        pop_vec;
  logic [N_CH-1:0]        push_ok;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fill[i*CNT_W +: CNT_W] = count[i];
      full[i]                = (count[i] == CNT_W'(DEPTH));
    end
  end

  // Grant is chosen from registered occupancies only; the pop itself still needs a free output slot.
  always_comb begin
    out_free    = !send_z_buffer || rdy_z_buffer;
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    best_cnt    = '0;
    if (ARB_MODE == 0) begin
      for (int off = 1; off <= N_CH; off++) begin
        cand = CH_W'((int'(last_grant) + off) % N_CH);
        if (!grant_valid && count[cand] != '0) begin
          grant_valid = 1'b1;
          grant       = cand;
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (count[i] > best_cnt) begin
          best_cnt    = count[i];
          grant_valid = 1'b1;
          grant       = CH_W'(i);
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      pop_vec[i] = out_free && grant_valid && (grant == CH_W'(i));
      // A full FIFO still takes a word when its head leaves on the same edge.
      push_ok[i] = load[i] && (!full[i] || pop_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= pix_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      overflow      <= '0;
      last_grant    <= CH_W'(N_CH - 1);
      send_z_buffer <= 1'b0;
      pix_out       <= '0;
      ch_out        <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push_ok[i] && !pop_vec[i]) count[i] <= count[i] + 1'b1;
        else if (!push_ok[i] && pop_vec[i]) count[i] <= count[i] - 1'b1;
        if (load[i] && !push_ok[i]) overflow[i] <= 1'b1;
      end
      if (out_free) begin
        if (grant_valid) begin
          send_z_buffer <= 1'b1;
          pix_out       <= mem[grant][rd_ptr[grant]];
          ch_out        <= grant;
          last_grant    <= grant;
        end else begin
          send_z_buffer <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_fifo_arbiter.sv
// Drives one round-robin and one fullest-first instance with shared stimulus and
// compares both against queue-based models every cycle, plus directed literal checks.
module tb_multi_fifo_arbiter;

  localparam int N = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] pix_in = '0;
  logic [3:0]  load = '0;
  logic        rdy = 1'b0;

  logic [3:0]  full_a, full_b, ovf_a, ovf_b;
  logic [15:0] fill_a, fill_b, pix_a, pix_b;
  logic        send_a, send_b;
  logic [1:0]  ch_a, ch_b;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mq [8][$];
  logic [3:0]  m_ovf [2];
  logic        m_send [2];
  logic [15:0] m_pix [2];
  int          m_ch [2];
  int          m_last [2];

  always #5 clk = ~clk;

  multi_fifo_arbiter #(.N_CH(N), .DEPTH(D), .PIXEL_WIDTH(16), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .pix_in(pix_in), .load(load), .full(full_a), .fill(fill_a),
    .overflow(ovf_a), .rdy_z_buffer(rdy), .send_z_buffer(send_a), .pix_out(pix_a), .ch_out(ch_a));

  multi_fifo_arbiter #(.N_CH(N), .DEPTH(D), .PIXEL_WIDTH(16), .ARB_MODE(1)) dut_ff (
    .clk(clk), .reset(reset), .pix_in(pix_in), .load(load), .full(full_b), .fill(fill_b),
    .overflow(ovf_b), .rdy_z_buffer(rdy), .send_z_buffer(send_b), .pix_out(pix_b), .ch_out(ch_b));

  task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mq[k].delete();
    for (int m = 0; m < 2; m++) begin
      m_ovf[m] = '0; m_send[m] = 1'b0; m_pix[m] = '0; m_ch[m] = 0; m_last[m] = N - 1;
    end
  endtask

  // One clock edge of behaviour: pick a channel, pop its head if the slot is free, then push.
  task automatic model_step(input logic [3:0] ld, input logic [63:0] pin, input logic r);
    for (int m = 0; m < 2; m++) begin
      int g = -1;
      int best = 0;
      if (m == 0) begin
        for (int off = 1; off <= N; off++) begin
          int c = (m_last[m] + off) % N;
          if (g < 0 && mq[m*4+c].size() > 0) g = c;
        end
      end else begin
        for (int i = 0; i < N; i++)
          if (mq[m*4+i].size() > best) begin best = mq[m*4+i].size(); g = i; end
      end
      if (!m_send[m] || r) begin
        if (g >= 0) begin
          m_pix[m] = mq[m*4+g].pop_front();
          m_ch[m] = g; m_send[m] = 1'b1; m_last[m] = g;
        end else m_send[m] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (ld[i]) begin
          if (mq[m*4+i].size() < D) mq[m*4+i].push_back(pin[i*16 +: 16]);
          else m_ovf[m][i] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < N; i++) begin
      check("fill", 0, 32'(fill_a[i*4 +: 4]), 32'(mq[i].size()));
      check("fill", 1, 32'(fill_b[i*4 +: 4]), 32'(mq[4+i].size()));
      check("full", 0, 32'(full_a[i]), 32'(mq[i].size() == D));
      check("full", 1, 32'(full_b[i]), 32'(mq[4+i].size() == D));
    end
    check("overflow", 0, 32'(ovf_a), 32'(m_ovf[0]));
    check("overflow", 1, 32'(ovf_b), 32'(m_ovf[1]));
    check("send", 0, 32'(send_a), 32'(m_send[0]));
    check("send", 1, 32'(send_b), 32'(m_send[1]));
    check("pix_out", 0, 32'(pix_a), 32'(m_pix[0]));
    check("pix_out", 1, 32'(pix_b), 32'(m_pix[1]));
    check("ch_out", 0, 32'(ch_a), 32'(m_ch[0]));
    check("ch_out", 1, 32'(ch_b), 32'(m_ch[1]));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic applyStimulus(input logic [3:0] ld, input logic [63:0] pin, input logic r);
    load = ld; pix_in = pin; rdy = r;
    model_step(ld, pin, r);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; load = '0; rdy = 1'b0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [63:0] word_for(input int c, input int j);
    logic [63:0] v;
    v = '0;
    v[c*16 +: 16] = 16'hC000 | 16'(c << 4) | 16'(j);
    return v;
  endfunction

  initial begin
    int exp_ch [7];
    exp_ch = '{1, 2, 3, 0, 1, 2, 3};
    model_reset();
    do_reset();

    // Single channel, two words, sink always ready.
    applyStimulus(4'b0001, 64'hA001, 1'b1);
    check("t1_empty_send", 0, 32'(send_a), 32'h0);
    applyStimulus(4'b0001, 64'hA002, 1'b1);
    check("t1_first", 0, 32'(pix_a), 32'hA001);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    check("t1_second", 0, 32'(pix_a), 32'hA002);
    check("t1_fill0", 0, 32'(fill_a[3:0]), 32'h0);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    check("t1_idle", 0, 32'(send_a), 32'h0);

    // Two words in every channel; round-robin starts at channel 0; then a 5-cycle stall.
    do_reset();
    applyStimulus(4'b1111, word_for(0,1)|word_for(1,1)|word_for(2,1)|word_for(3,1), 1'b0);
    applyStimulus(4'b1111, word_for(0,2)|word_for(1,2)|word_for(2,2)|word_for(3,2), 1'b0);
    check("t2_grant0", 0, 32'(ch_a), 32'h0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0000, 64'h0, 1'b0);
      check("t5_hold_pix", 0, 32'(pix_a), 32'hC001);
      check("t5_hold_fill1", 0, 32'(fill_a[7:4]), 32'h2);
    end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(4'b0000, 64'h0, 1'b1);
      check("t2_grant", 0, 32'(ch_a), 32'(exp_ch[k]));
    end
    applyStimulus(4'b0000, 64'h0, 1'b1);
    check("t2_drained", 0, 32'(send_a), 32'h0);

    // Fullest-first with occupancies 1,3,3,0 while the output is held.
    do_reset();
    applyStimulus(4'b1000, 64'h7777_0000_0000_0000, 1'b0);
    applyStimulus(4'b0111, 64'h0000_2221_1111_0001, 1'b0);
    applyStimulus(4'b0110, 64'h0000_2222_1112_0000, 1'b0);
    applyStimulus(4'b0110, 64'h0000_2223_1113_0000, 1'b0);
    check("t3_fill1", 1, 32'(fill_b[7:4]), 32'h3);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    check("t3_first", 1, 32'(ch_b), 32'h1);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    check("t3_second", 1, 32'(ch_b), 32'h2);
    applyStimulus(4'b0000, 64'h0, 1'b1);
    check("t3_third", 1, 32'(ch_b), 32'h1);

    // Overflow on channel 2: one word parks in the output, eight fill the FIFO, the tenth is dropped.
    do_reset();
    for (int k = 1; k <= 10; k++) applyStimulus(4'b0100, word_for(2, k), 1'b0);
    check("t4_full", 0, 32'(full_a[2]), 32'h1);
    check("t4_ovf", 0, 32'(ovf_a[2]), 32'h1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0000, 64'h0, 1'b1);
      if (send_a) check("t4_no_dropped", 0, 32'(pix_a == 16'hC02A), 32'h0);
    end
    check("t4_ovf_sticky", 0, 32'(ovf_a[2]), 32'h1);
    check("t4_fill_empty", 0, 32'(fill_a[11:8]), 32'h0);

    // Full channel 1 with simultaneous push and pop, then reset in the middle of traffic.
    do_reset();
    for (int k = 1; k <= 9; k++) applyStimulus(4'b0010, word_for(1, k), 1'b0);
    check("t6_full", 0, 32'(fill_a[7:4]), 32'h8);
    applyStimulus(4'b0010, word_for(1, 15), 1'b1);
    check("t6_fill_kept", 0, 32'(fill_a[7:4]), 32'h8);
    check("t6_no_ovf", 0, 32'(ovf_a[1]), 32'h0);
    applyStimulus(4'b0011, 64'h0, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    check("t6_rst_send", 0, 32'(send_a), 32'h0);
    check("t6_rst_pix", 0, 32'(pix_a), 32'h0);
    check("t6_rst_fill", 0, 32'(fill_a), 32'h0);
    checkOutput();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic with back-pressure and one asynchronous reset.
    for (int k = 0; k < 800; k++) begin
      if (k == 400) do_reset();
      applyStimulus(4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
